// File: rtl/multiway_traffic_controller_pkg.sv
// rtl/multiway_traffic_controller_pkg.sv - shared light/phase encodings and parameter defaults
package multiway_traffic_controller_pkg;

   localparam int DEF_NUM_WAYS     = 4;
   localparam int DEF_MIN_GREEN    = 5;
   localparam int DEF_MAX_GREEN    = 20;
   localparam int DEF_YELLOW_TIME  = 3;
   localparam int DEF_ALL_RED_TIME = 1;

   typedef logic [2:0] light_t;

   localparam light_t LIGHT_RED    = 3'b100;
   localparam light_t LIGHT_YELLOW = 3'b010;
   localparam light_t LIGHT_GREEN  = 3'b001;

   localparam logic [1:0] PHASE_GREEN   = 2'b00;
   localparam logic [1:0] PHASE_YELLOW  = 2'b01;
   localparam logic [1:0] PHASE_ALL_RED = 2'b10;

endpackage

// File: rtl/multiway_traffic_controller_rr_next_way.sv
// rtl/multiway_traffic_controller_rr_next_way.sv - circular priority search starting after a given index
module rr_next_way
   import multiway_traffic_controller_pkg::*;
#(
   parameter int NUM_WAYS = DEF_NUM_WAYS,
   parameter int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic [WAY_W-1:0]    start,
   input  logic [NUM_WAYS-1:0] req,
   output logic [WAY_W-1:0]    next_way
);

   logic [WAY_W:0] idx;

   // Walk offsets from far to near so the nearest requester after start wins.
   always_comb begin
      next_way = start;
      idx      = '0;
      for (int k = NUM_WAYS; k >= 1; k--) begin
         idx = {1'b0, start} + (WAY_W+1)'(k);
         if (idx >= (WAY_W+1)'(NUM_WAYS)) begin
            idx = idx - (WAY_W+1)'(NUM_WAYS);
         end
         if (req[idx[WAY_W-1:0]]) begin
            next_way = idx[WAY_W-1:0];
         end
      end
   end

endmodule

// File: rtl/multiway_traffic_controller.sv
// rtl/multiway_traffic_controller.sv - round-robin multi-approach traffic light FSM
module multiway_traffic_controller
   import multiway_traffic_controller_pkg::*;
#(
   parameter int NUM_WAYS     = DEF_NUM_WAYS,
   parameter int MIN_GREEN    = DEF_MIN_GREEN,
   parameter int MAX_GREEN    = DEF_MAX_GREEN,
   parameter int YELLOW_TIME  = DEF_YELLOW_TIME,
   parameter int ALL_RED_TIME = DEF_ALL_RED_TIME
) (
   input  logic                        clock,
   input  logic                        clear_n,
   input  logic [NUM_WAYS-1:0]         sensor,
   output logic [3*NUM_WAYS-1:0]       lights,
   output logic [$clog2(NUM_WAYS)-1:0] active_way,
   output logic [1:0]                  phase,
   output logic [NUM_WAYS-1:0]         pending
);

   localparam int WAY_W   = $clog2(NUM_WAYS);
   localparam int TIMER_W = $clog2(MAX_GREEN + 1);

   localparam logic [TIMER_W-1:0] T_MIN_M1 = TIMER_W'(MIN_GREEN - 1);
   localparam logic [TIMER_W-1:0] T_MAX    = TIMER_W'(MAX_GREEN);
   localparam logic [TIMER_W-1:0] T_MAX_M1 = TIMER_W'(MAX_GREEN - 1);
   localparam logic [TIMER_W-1:0] T_YEL_M1 = TIMER_W'(YELLOW_TIME - 1);
   localparam logic [TIMER_W-1:0] T_AR_M1  = TIMER_W'(ALL_RED_TIME - 1);

   logic [1:0]          phase_q, phase_d;
   logic [WAY_W-1:0]    way_q, way_d;
   logic [WAY_W-1:0]    target_q, target_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [NUM_WAYS-1:0] pending_q, pending_d;
   logic [NUM_WAYS-1:0] way_mask, set_mask, clr_mask;
   logic [WAY_W-1:0]    rr_way;
   logic                others_pending;

   assign way_mask       = NUM_WAYS'(1) << way_q;
   assign others_pending = |(pending_q & ~way_mask);

   rr_next_way #(
      .NUM_WAYS (NUM_WAYS)
   ) u_rr_next_way (
      .start    (way_q),
      .req      (pending_q),
      .next_way (rr_way)
   );

   always_comb begin
      phase_d  = phase_q;
      way_d    = way_q;
      target_d = target_q;
      timer_d  = (timer_q == T_MAX) ? timer_q : timer_q + TIMER_W'(1);
      set_mask = (phase_q == PHASE_GREEN) ? (sensor & ~way_mask) : sensor;
      clr_mask = '0;
      case (phase_q)
         PHASE_GREEN: begin
            // The current approach keeps green while its own car is present, up to the cap.
            if (timer_q >= T_MIN_M1 && others_pending &&
                (!sensor[way_q] || timer_q >= T_MAX_M1)) begin
               phase_d  = PHASE_YELLOW;
               target_d = rr_way;
               timer_d  = '0;
            end
         end
         PHASE_YELLOW: begin
            if (timer_q >= T_YEL_M1) begin
               phase_d = PHASE_ALL_RED;
               timer_d = '0;
            end
         end
         PHASE_ALL_RED: begin
            if (timer_q >= T_AR_M1) begin
               phase_d  = PHASE_GREEN;
               way_d    = target_q;
               timer_d  = '0;
               clr_mask = NUM_WAYS'(1) << target_q;
            end
         end
         default: begin
            phase_d  = PHASE_GREEN;
            way_d    = '0;
            timer_d  = '0;
            clr_mask = NUM_WAYS'(1);
         end
      endcase
      pending_d = (pending_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         phase_q   <= PHASE_GREEN;
         way_q     <= '0;
         target_q  <= '0;
         timer_q   <= '0;
         pending_q <= '0;
      end else begin
         phase_q   <= phase_d;
         way_q     <= way_d;
         target_q  <= target_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   always_comb begin
      lights = '0;
      for (int i = 0; i < NUM_WAYS; i++) begin
         if (WAY_W'(i) == way_q && phase_q == PHASE_GREEN) begin
            lights[3*i +: 3] = LIGHT_GREEN;
         end else if (WAY_W'(i) == way_q && phase_q == PHASE_YELLOW) begin
            lights[3*i +: 3] = LIGHT_YELLOW;
         end else begin
            lights[3*i +: 3] = LIGHT_RED;
         end
      end
   end

   assign active_way = way_q;
   assign phase      = phase_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_multiway_traffic_controller.sv
// tb/tb_multiway_traffic_controller.sv - directed and random checks against a timeline reference model
module tb_multiway_traffic_controller;

   localparam int N     = 4;
   localparam int MIN_G = 5;
   localparam int MAX_G = 20;
   localparam int YEL   = 3;
   localparam int AR    = 1;

   logic           clock = 1'b0;
   logic           clear_n = 1'b0;
   logic [N-1:0]   sensor = '0;
   logic [3*N-1:0] lights;
   logic [1:0]     active_way;
   logic [1:0]     phase;
   logic [N-1:0]   pending;

   int errors = 0;
   int checks = 0;

   // Reference model: phase kind (0 green, 1 yellow, 2 all-red), owner, and the tick the phase began.
   int m_phase, m_way, m_target, m_start, now;
   bit m_pend[N];

   always #5 clock = ~clock;

   multiway_traffic_controller dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .sensor     (sensor),
      .lights     (lights),
      .active_way (active_way),
      .phase      (phase),
      .pending    (pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3*N-1:0] m_lights();
      logic [3*N-1:0] l;
      for (int i = 0; i < N; i++) l[3*i +: 3] = 3'b100;
      if (m_phase == 0) l[3*m_way +: 3] = 3'b001;
      else if (m_phase == 1) l[3*m_way +: 3] = 3'b010;
      return l;
   endfunction

   function automatic logic [N-1:0] m_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_way    = 0;
      m_target = 0;
      m_start  = now;
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] s);
      bit old[N];
      int el, t;
      bit other, found;
      old   = m_pend;
      el    = now - m_start;
      t     = (el > MAX_G) ? MAX_G : el;
      other = 1'b0;
      for (int j = 0; j < N; j++) if (old[j] && j != m_way) other = 1'b1;
      for (int j = 0; j < N; j++) if (s[j] && !(m_phase == 0 && j == m_way)) m_pend[j] = 1'b1;
      if (m_phase == 0) begin
         if (t >= MIN_G - 1 && other && (!s[m_way] || t >= MAX_G - 1)) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
               if (!found && old[(m_way + k) % N]) begin
                  m_target = (m_way + k) % N;
                  found    = 1'b1;
               end
            end
            m_phase = 1;
            m_start = now + 1;
         end
      end else if (m_phase == 1) begin
         if (el == YEL - 1) begin
            m_phase = 2;
            m_start = now + 1;
         end
      end else begin
         if (el == AR - 1) begin
            m_phase         = 0;
            m_way           = m_target;
            m_pend[m_target] = 1'b0;
            m_start         = now + 1;
         end
      end
      now++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_lights"}, 32'(lights), 32'(m_lights()));
      chk({tag, "_way"}, 32'(active_way), 32'(m_way));
      chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
      chk({tag, "_pending"}, 32'(pending), 32'(m_pend_vec()));
   endtask

   task automatic tick(input logic [N-1:0] s, input string tag);
      sensor = s;
      @(posedge clock);
      model_step(s);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset(input string tag);
      clear_n = 1'b0;
      sensor  = '0;
      #1;
      chk({tag, "_lights"}, 32'(lights), 32'h921);
      chk({tag, "_way"}, 32'(active_way), 32'd0);
      chk({tag, "_phase"}, 32'(phase), 32'd0);
      chk({tag, "_pending"}, 32'(pending), 32'd0);
      chk({tag, "_timer"}, 32'(dut.timer_q), 32'd0);
      model_reset();
      #1;
      clear_n = 1'b1;
   endtask

   task automatic wait_green(input int w, input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick('0, tag);
         if (phase == 2'b00 && active_way == 2'(w)) hit = 1'b1;
      end
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic wait_yellow(input string tag);
      bit hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
         tick('0, tag);
         if (phase == 2'b01) hit = 1'b1;
      end
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic record_greens(input int cycles, input string tag, output int order[$]);
      int prev;
      prev = int'(active_way);
      order = {};
      for (int i = 0; i < cycles; i++) begin
         tick('0, tag);
         if (phase == 2'b00 && int'(active_way) != prev) begin
            order.push_back(int'(active_way));
            prev = int'(active_way);
         end
      end
   endtask

   initial begin
      int order[$];
      int bad;
      int first_yel;
      logic [11:0] exp_l [9];
      logic [N-1:0] s, prev_s;

      now = 0;
      model_reset();
      #2;

      // Idle: approach 0 keeps green with nothing pending.
      do_reset("rst0");
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick('0, "idle");
         if (lights !== 12'h921 || pending !== '0) bad++;
      end
      chk("idle_bad_cycles", 32'(bad), 32'd0);

      // Single pulse on approach 2 in cycle 0.
      do_reset("rst1");
      exp_l = '{12'h921, 12'h921, 12'h921, 12'h921, 12'h922, 12'h922, 12'h922, 12'h924, 12'h864};
      for (int t = 0; t < 9; t++) begin
         tick((t == 0) ? 4'b0100 : 4'b0000, "pulse2");
         chk($sformatf("pulse2_lights_t%0d", t), 32'(lights), 32'(exp_l[t]));
         if (t == 0) chk("pulse2_pend_set", 32'(pending), 32'h4);
      end
      chk("pulse2_pend_clr", 32'(pending), 32'h0);

      // Approaches 0 and 1 both held: green capped at MAX_GREEN.
      do_reset("rst2");
      first_yel = -1;
      for (int t = 0; t < 24; t++) begin
         tick(4'b0011, "cap");
         if (phase == 2'b01 && first_yel < 0) first_yel = t;
         if (t == 22) chk("cap_allred_t22", 32'(phase), 32'd2);
      end
      chk("cap_first_yellow", 32'(first_yel), 32'd19);
      chk("cap_next_way", 32'(active_way), 32'd1);
      chk("cap_next_phase", 32'(phase), 32'd0);

      // Round-robin order from approach 1 with 0 and 3 pending.
      do_reset("rst3");
      tick(4'b0010, "rr");
      wait_green(1, "rr_w1");
      tick(4'b1001, "rr");
      record_greens(40, "rr", order);
      chk("rr_order_n", 32'(order.size()), 32'd2);
      chk("rr_order_0", 32'(order.size() > 0 ? order[0] : -1), 32'd3);
      chk("rr_order_1", 32'(order.size() > 1 ? order[1] : -1), 32'd0);

      // Own request during own yellow is re-served after the target.
      do_reset("rst4");
      tick(4'b0010, "own");
      wait_green(1, "own_w1");
      tick(4'b0100, "own");
      wait_yellow("own_y");
      tick(4'b0010, "own");
      chk("own_pend1", 32'(pending[1]), 32'd1);
      chk("own_still_yellow", 32'(phase), 32'd1);
      record_greens(40, "own", order);
      chk("own_order_n", 32'(order.size()), 32'd2);
      chk("own_order_0", 32'(order.size() > 0 ? order[0] : -1), 32'd2);
      chk("own_order_1", 32'(order.size() > 1 ? order[1] : -1), 32'd1);

      // Async reset in the second yellow cycle of approach 2.
      do_reset("rst5");
      tick(4'b0100, "abort");
      wait_green(2, "abort_w2");
      tick(4'b0001, "abort");
      wait_yellow("abort_y");
      tick(4'b0000, "abort");
      chk("abort_yellow2", 32'(phase), 32'd1);
      chk("abort_way2", 32'(active_way), 32'd2);
      do_reset("abort_rst");
      tick('0, "after_abort");

      // Random sensor traffic against the model, with one mid-run reset.
      prev_s = '0;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset("rnd_rst");
         if ($urandom_range(0, 3) == 0) begin
            s = prev_s;
         end else begin
            for (int j = 0; j < N; j++) s[j] = ($urandom_range(0, 7) == 0);
         end
         prev_s = s;
         tick(s, "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multiway_traffic_controller.md
MULTIWAY_TRAFFIC_CONTROLLER -- requirements
Module: multiway_traffic_controller

Interface
REQ-001 Parameter NUM_WAYS, default 4: number of approaches, legal range 2..8.
REQ-002 Parameter MIN_GREEN, default 5: minimum green duration in clock cycles, at least 1.
REQ-003 Parameter MAX_GREEN, default 20: green cap under competing demand, at least MIN_GREEN.
REQ-004 Parameter YELLOW_TIME, default 3: exact yellow duration in cycles, at least 1.
REQ-005 Parameter ALL_RED_TIME, default 1: exact all-red clearance in cycles, at least 1.
REQ-006 clock  input  1  single clock; all state changes on posedge.
REQ-007 clear_n  input  1  asynchronous, active-low reset.
REQ-008 sensor  input  NUM_WAYS  bit i high means a car is present on approach i; level or single-cycle pulse.
REQ-009 lights  output  3*NUM_WAYS  per-approach one-hot light; bits [3i+2:3i] belong to approach i; RED=100, YELLOW=010, GREEN=001.
REQ-010 active_way  output  clog2(NUM_WAYS)  index of the approach currently owning green, yellow or all-red.
REQ-011 phase  output  2  current phase: 00 GREEN, 01 YELLOW, 10 ALL_RED.
REQ-012 pending  output  NUM_WAYS  latched unserved requests.

Function
REQ-013 FSM states: GREEN, YELLOW, ALL_RED.
REQ-014 Outputs are Moore outputs, decoded only from registered state, active_way and pending.
REQ-015 Light decode:
- lights[active_way] = GREEN in the GREEN phase and YELLOW in the YELLOW phase.
- Every other approach is RED in every phase.
- All approaches are RED in ALL_RED.
REQ-016 Phase timer: width clog2(MAX_GREEN+1); cleared to 0 on phase entry; increments each cycle; saturates at MAX_GREEN.
REQ-017 Request latch pending[i]:
- Set on any cycle where sensor[i]=1, except when i == active_way and phase == GREEN.
- Cleared on the cycle approach i enters GREEN; clear wins over a simultaneous set.
REQ-018 GREEN to YELLOW happens at the posedge where all of the following hold:
- timer >= MIN_GREEN-1;
- some pending[j]=1 with j != active_way;
- either sensor[active_way]=0 or timer >= MAX_GREEN-1.
REQ-019 With no other approach pending, GREEN holds indefinitely whatever the value of sensor[active_way].
REQ-020 At the GREEN to YELLOW transition, latch the target: the first j with pending[j]=1, searching circularly from active_way+1 (round-robin).
REQ-021 YELLOW lasts exactly YELLOW_TIME cycles, then ALL_RED.
REQ-022 ALL_RED lasts exactly ALL_RED_TIME cycles, then GREEN with active_way set to the latched target.
REQ-023 Sensor changes during YELLOW or ALL_RED only update pending; they never alter the latched target.
REQ-024 The state register never holds an illegal phase encoding; any illegal encoding recovers to GREEN on approach 0.

Reset
REQ-025 While clear_n=0, asynchronously:
- phase=GREEN, active_way=0, timer=0, pending=0, latched target=0;
- lights show approach 0 GREEN and all others RED.
REQ-026 Reset asserted mid-operation aborts the current phase immediately, with no yellow or all-red sequence.
REQ-027 First state change is possible at the first posedge after clear_n rises.

Structure
REQ-028 A shared package holds:
- the light encodings RED, YELLOW, GREEN;
- the phase encodings;
- the parameter default constants.
REQ-029 One sub-module, rr_next_way, is the combinational circular priority search from a start index over a request vector (REQ-020).
REQ-030 The top module holds the FSM, timer, request latches and light decode.

Verification
All scenarios use the default parameters and take cycle 0 as the first posedge after reset release.
REQ-031 No sensor activity for 100 cycles -> approach 0 GREEN throughout, others RED, pending=0.
REQ-032 Single-cycle pulse on sensor[2] in cycle 0 -> approach 0 GREEN cycles 0-4, YELLOW 5-7, all RED 8, approach 2 GREEN from 9, pending[2] cleared at 9.
REQ-033 sensor[0] and sensor[1] held high from cycle 0:
- approach 0 GREEN for exactly 20 cycles (0-19), then YELLOW 20-22, all RED 23;
- approach 1 GREEN at 24.
REQ-034 Approach 1 green, with pending[0] and pending[3] set -> service order is 3 then 0, each preceded by 3 yellow and 1 all-red cycle.
REQ-035 clear_n pulsed low during the second YELLOW cycle of approach 2 -> lights immediately show approach 0 GREEN, pending=0, timer=0.
REQ-036 sensor[1] pulsed during approach 1's own YELLOW -> pending[1] set, and approach 1 is served again after the current target.
